// File: rtl/mem_resp_pkg.sv
// Package: mem_resp_pkg
// Shared types and lane helpers for the mem_responder slice.
//  - state_t : responder FSM states
//  - SZ_*    : access-size encodings on the Size port (2'b11 behaves as word)
//  - helpers : aligned lane offset, misalign detection, byte enables,
//              store lane replication and load right-alignment.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Low address bits forced to the natural alignment of the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  // True when the raw byte address is not naturally aligned for the size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  // Byte-write enables for an (already aligned) lane offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across all lanes; byte enables pick the lane.
  function automatic logic [31:0] wr_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Shift the selected lane(s) down to bit 0 and zero the upper bits.
  function automatic logic [31:0] read_align(input logic [1:0] size, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      SZ_BYTE: return {24'h000000, sh[7:0]};
      SZ_HALF: return {16'h0000, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Module: byte_lane_ram
// Single-port DEPTH_WORDS x 32 RAM with four byte-write enables and a
// registered read port. Contents are never reset.
//  clk   in  clock, rising edge
//  addr  in  word index
//  we    in  write strobe (qualified per byte by be)
//  be    in  byte-write enables, bit n covers wdata[8n+7:8n]
//  wdata in  write data
//  rdata out registered read data (old contents on a write cycle)
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Module: mem_responder
// Memory-side responder for the multicycle CPU: latches a load/store on Req
// in IDLE, waits WAIT_STATES cycles, performs the access, and pulses Ready
// for one cycle in DONE with right-aligned, zero-extended load data.
//  Clk      in  clock, rising edge
//  Reset    in  asynchronous reset, active low
//  Req      in  request, sampled only in IDLE
//  Wr       in  1 = store, 0 = load
//  Size     in  00/11 word, 01 half, 10 byte
//  Addr     in  byte address (word index wraps modulo DEPTH_WORDS)
//  WData    in  right-aligned store data
//  Ready    out one-cycle completion pulse
//  RData    out load data, nonzero only while Ready = 1
//  Busy     out high in every state except IDLE
//  AddrErr  out misalign flag pulsing with Ready
// Configuration macro MISALIGN_EXC_EN: when defined, misaligned half/word
// accesses complete with AddrErr = 1, no RAM write and RData = 0; when
// undefined, the low address bits are truncated and AddrErr stays 0.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Wr,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  output logic              Ready,
  output logic [31:0]       RData,
  output logic              Busy,
  output logic              AddrErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t        state_r;
  logic          wr_r;
  logic [1:0]    size_r;
  logic [1:0]    lo_r;
  logic [AW-1:0] idx_r;
  logic [31:0]   wdata_r;
  logic [3:0]    cnt_r;

  logic [AW-1:0] ram_addr_s;
  logic          ram_we_s;
  logic [31:0]   ram_q_s;
  logic [1:0]    lo_a_s;
  logic          err_s;
  logic          unused_addr_s;

  assign unused_addr_s = ^Addr[ADDR_W-1:AW+2];
  assign lo_a_s        = align_lo(size_r, lo_r);

`ifdef MISALIGN_EXC_EN
  assign err_s = is_misaligned(size_r, lo_r);
`else
  assign err_s = 1'b0;
`endif

  // In IDLE the RAM reads the incoming address so the word is ready by ACCESS
  // even with zero wait states; afterwards it keeps reading the latched index.
  always_comb begin
    ram_addr_s = idx_r;
    ram_we_s   = 1'b0;
    if (state_r == IDLE) begin
      ram_addr_s = Addr[AW+1:2];
    end else begin
      ram_addr_s = idx_r;
    end
    if (state_r == ACCESS) begin
      ram_we_s = wr_r & ~err_s;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (Clk),
    .addr  (ram_addr_s),
    .we    (ram_we_s),
    .be    (byte_en(size_r, lo_a_s)),
    .wdata (wr_lanes(size_r, wdata_r)),
    .rdata (ram_q_s)
  );

  // Responder FSM with request latches, wait counter and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      wr_r    <= 1'b0;
      size_r  <= SZ_WORD;
      lo_r    <= 2'b00;
      idx_r   <= '0;
      wdata_r <= 32'h0000_0000;
      cnt_r   <= 4'd0;
      Ready   <= 1'b0;
      RData   <= 32'h0000_0000;
      Busy    <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      Ready   <= 1'b0;
      AddrErr <= 1'b0;
      RData   <= 32'h0000_0000;
      case (state_r)
        IDLE: begin
          if (Req) begin
            wr_r    <= Wr;
            size_r  <= Size;
            lo_r    <= Addr[1:0];
            idx_r   <= Addr[AW+1:2];
            wdata_r <= WData;
            Busy    <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_r <= ACCESS;
            end else begin
              state_r <= WAIT;
              cnt_r   <= WAIT_LOAD;
            end
          end else begin
            Busy <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ACCESS;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ACCESS: begin
          state_r <= DONE;
          Ready   <= 1'b1;
          AddrErr <= err_s;
          if (!wr_r && !err_s) begin
            RData <= read_align(size_r, lo_a_s, ram_q_s);
          end else begin
            RData <= 32'h0000_0000;
          end
        end
        DONE: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int W      = 2;
  localparam int DEPTH  = 256;
  localparam int DEPTH0 = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req, Wr;
  logic [1:0]  Size;
  logic [31:0] Addr, WData;
  logic        Ready, Busy, AddrErr;
  logic [31:0] RData;

  logic        Req0, Wr0;
  logic [1:0]  Size0;
  logic [31:0] Addr0, WData0;
  logic        Ready0, Busy0, AddrErr0;
  logic [31:0] RData0;

  always #5 Clk = ~Clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W), .ADDR_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Size(Size), .Addr(Addr),
    .WData(WData), .Ready(Ready), .RData(RData), .Busy(Busy), .AddrErr(AddrErr)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(Req0), .Wr(Wr0), .Size(Size0), .Addr(Addr0),
    .WData(WData0), .Ready(Ready0), .RData(RData0), .Busy(Busy0), .AddrErr(AddrErr0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mb [DEPTH*4];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte-addressed reference memory: the access covers nbytes starting at the
  // naturally aligned offset within the wrapped word.
  function automatic void model_access(input logic wr, input logic [1:0] size,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic err);
    int nbytes, off, base;
    nbytes = (size == 2'b10) ? 1 : ((size == 2'b01) ? 2 : 4);
    off    = int'(addr % 32'd4);
    off    = off - (off % nbytes);
    base   = int'((addr / 32'd4) % DEPTH) * 4 + off;
    rd     = 32'h0;
    err    = 1'b0;
`ifdef MISALIGN_EXC_EN
    if ((addr % nbytes) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    for (int i = 0; i < nbytes; i++) begin
      if (wr) mb[base+i] = wdata[8*i +: 8];
      else    rd[8*i +: 8] = mb[base+i];
    end
  endfunction

  task automatic issue(input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   t;
    t = 0;
    while (Busy !== 1'b0 && t < 40) begin @(negedge Clk); t++; end
    Req = 1'b1; Wr = wr; Size = size; Addr = addr; WData = wdata;
    model_access(wr, size, addr, wdata, e.rdata, e.err);
    e.cyc = cyc + W + 2;
    sbq.push_back(e);
    @(negedge Clk);
    Req = 1'b0;
    t = 0;
    while (Busy !== 1'b0 && t < 40) begin @(negedge Clk); t++; end
    check("busy_timeout", 32'(t < 40), 32'd1);
  endtask

  // Scoreboard monitor: every Ready pulse pops one expected response.
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if (Ready === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rdata", RData, e.rdata);
          check("addr_err", 32'(AddrErr), 32'(e.err));
          check("ready_cycle", cyc, e.cyc);
          check("busy_at_ready", 32'(Busy), 32'd1);
        end
      end else begin
        check("rdata_idle", RData, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Req = 1'b0; Wr = 1'b0; Size = 2'b00; Addr = 32'h0; WData = 32'h0;
    Req0 = 1'b0; Wr0 = 1'b0; Size0 = 2'b00; Addr0 = 32'h0; WData0 = 32'h0;
    repeat (3) @(negedge Clk);
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_rdata", RData, 32'h0);
    check("rst_addrerr", 32'(AddrErr), 32'd0);
    check("rst_busy0", 32'(Busy0), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Fill every word so later loads have defined contents.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 2'b00, 32'(i * 4), $urandom);

    // Directed word, lane and misalign cases.
    issue(1'b1, 2'b00, 32'h20, 32'hDEADBEEF);
    issue(1'b0, 2'b00, 32'h20, 32'h0);
    issue(1'b1, 2'b00, 32'h20, 32'h11223344);
    issue(1'b1, 2'b10, 32'h21, 32'h000000AA);
    issue(1'b0, 2'b00, 32'h20, 32'h0);
    issue(1'b0, 2'b01, 32'h22, 32'h0);
    issue(1'b0, 2'b00, 32'h23, 32'h0);
    issue(1'b1, 2'b01, 32'h27, 32'h0000CAFE);
    issue(1'b0, 2'b00, 32'h24, 32'h0);
    issue(1'b1, 2'b00, 32'(DEPTH * 4), 32'hA5A55A5A);
    issue(1'b0, 2'b00, 32'h0, 32'h0);

    // Reset in the middle of a store's wait phase abandons the write.
    Req = 1'b1; Wr = 1'b1; Size = 2'b00; Addr = 32'h10; WData = 32'hBADBAD00;
    @(negedge Clk);
    Req = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check("midrst_ready", 32'(Ready), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_rdata", RData, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    issue(1'b0, 2'b00, 32'h10, 32'h0);

    // Randomized traffic over the full address range (wraps silently).
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
    end

    // Zero-wait instance: Req held high -> Ready every third cycle.
    Req0 = 1'b1; Wr0 = 1'b1; Size0 = 2'b00; Addr0 = 32'(DEPTH0 * 4); WData0 = 32'h12345678;
    for (int k = 0; k < 30; k++) begin
      check("w0_busy", 32'(Busy0), 32'((k % 3) != 0));
      check("w0_ready", 32'(Ready0), 32'((k % 3) == 2));
      @(negedge Clk);
    end
    Req0 = 1'b0;
    @(negedge Clk);
    Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 32'h0;
    @(negedge Clk);
    Req0 = 1'b0;
    @(negedge Clk);
    check("w0_wrap_ready", 32'(Ready0), 32'd1);
    check("w0_wrap_rdata", RData0, 32'h12345678);

    repeat (6) @(negedge Clk);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
